// File: rtl/barril_ctrl.sv
// Barrel slot scheduler: per-frame slot update sequence, periodic spawning and per-pixel barrel select.
// Optional macro BARRIL_RANDOM_EN adds an LFSR that randomises spawn direction and edge-drop direction.
module barril_ctrl #(
  parameter int N_BARRILES   = 4,
  parameter int SPAWN_H      = 40,
  parameter int SPAWN_V      = 80,
  parameter int H_MIN        = 16,
  parameter int H_MAX        = 608,
  parameter int LEVEL_H      = 64,
  parameter int V_BOTTOM     = 400,
  parameter int SPEED        = 2,
  parameter int FALL_SPEED   = 4,
  parameter int SPAWN_PERIOD = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       spawn_en,
  input  logic       clear,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic [9:0] curr_h,
  output logic [9:0] curr_v,
  output logic       display_barril,
  output logic       busy,
  output logic       overrun,
  output logic [3:0] active_count
);

  localparam int IW = (N_BARRILES > 1) ? $clog2(N_BARRILES) : 1;
  localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {S_WAIT, S_UPD, S_SPAWN} ctl_st_t;
  typedef enum logic [1:0] {SL_IDLE, SL_ROLL_R, SL_ROLL_L, SL_FALL} slot_st_t;

  ctl_st_t           state_r;
  logic [IW-1:0]     idx_r;
  logic [CW-1:0]     spawn_cnt_r;
  logic              busy_r;
  logic              overrun_r;
  logic [3:0]        active_r;
  slot_st_t          slot_st_r [N_BARRILES];
  logic [9:0]        h_r       [N_BARRILES];
  logic [9:0]        v_r       [N_BARRILES];
  logic [9:0]        tgt_r     [N_BARRILES];
  logic              dir_r     [N_BARRILES];

`ifdef BARRIL_RANDOM_EN
  logic [7:0]        lfsr_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`endif

  slot_st_t   cur_st_s, nxt_st_s, spawn_st_s;
  logic [9:0] cur_h_s, cur_v_s, cur_tgt_s;
  logic [9:0] nxt_h_s, nxt_v_s, nxt_tgt_s;
  logic       cur_dir_s, nxt_dir_s, drop_r_dir_s;
  logic [10:0] h_inc_s, v_lvl_s, v_fall_s;
  logic        spawn_hit_s;
  logic [IW-1:0] spawn_idx_s;
  logic [N_BARRILES-1:0] cover_s;
  logic        sel_hit_s;
  logic [9:0]  sel_h_s, sel_v_s;
  logic [3:0]  active_s;

  // Next state of the slot currently addressed by the update sequence
  always_comb begin
    cur_st_s  = slot_st_r[idx_r];
    cur_h_s   = h_r[idx_r];
    cur_v_s   = v_r[idx_r];
    cur_tgt_s = tgt_r[idx_r];
    cur_dir_s = dir_r[idx_r];
    nxt_st_s  = cur_st_s;
    nxt_h_s   = cur_h_s;
    nxt_v_s   = cur_v_s;
    nxt_tgt_s = cur_tgt_s;
    nxt_dir_s = cur_dir_s;
    h_inc_s   = {1'b0, cur_h_s} + 11'(SPEED);
    v_lvl_s   = {1'b0, cur_v_s} + 11'(LEVEL_H);
    v_fall_s  = {1'b0, cur_v_s} + 11'(FALL_SPEED);
`ifdef BARRIL_RANDOM_EN
    drop_r_dir_s = lfsr_r[1] ? DIR_R : DIR_L;
`else
    drop_r_dir_s = DIR_L;
`endif
    case (cur_st_s)
      SL_ROLL_R: begin
        if (h_inc_s >= 11'(H_MAX)) begin
          nxt_h_s   = 10'(H_MAX);
          nxt_dir_s = drop_r_dir_s;
          if (v_lvl_s > 11'(V_BOTTOM)) begin
            nxt_st_s = SL_IDLE;
          end else begin
            nxt_tgt_s = v_lvl_s[9:0];
            nxt_st_s  = SL_FALL;
          end
        end else begin
          nxt_h_s = h_inc_s[9:0];
        end
      end
      SL_ROLL_L: begin
        if ({1'b0, cur_h_s} <= 11'(H_MIN + SPEED)) begin
          nxt_h_s   = 10'(H_MIN);
          nxt_dir_s = DIR_R;
          if (v_lvl_s > 11'(V_BOTTOM)) begin
            nxt_st_s = SL_IDLE;
          end else begin
            nxt_tgt_s = v_lvl_s[9:0];
            nxt_st_s  = SL_FALL;
          end
        end else begin
          nxt_h_s = cur_h_s - 10'(SPEED);
        end
      end
      SL_FALL: begin
        if (v_fall_s >= {1'b0, cur_tgt_s}) begin
          nxt_v_s  = cur_tgt_s;
          nxt_st_s = (cur_dir_s == DIR_L) ? SL_ROLL_L : SL_ROLL_R;
        end else begin
          nxt_v_s = v_fall_s[9:0];
        end
      end
      default: nxt_st_s = cur_st_s;
    endcase
  end

  // Lowest-index idle slot for spawning, and the direction a new barrel starts in
  always_comb begin
    spawn_hit_s = 1'b0;
    spawn_idx_s = {IW{1'b0}};
    for (int i = N_BARRILES - 1; i >= 0; i--) begin
      spawn_hit_s = spawn_hit_s | (slot_st_r[i] == SL_IDLE);
      spawn_idx_s = (slot_st_r[i] == SL_IDLE) ? IW'(i) : spawn_idx_s;
    end
`ifdef BARRIL_RANDOM_EN
    spawn_st_s = lfsr_r[0] ? SL_ROLL_L : SL_ROLL_R;
`else
    spawn_st_s = SL_ROLL_R;
`endif
  end

  // Per-slot coverage of the current pixel (strict bounds on both axes)
  always_comb begin
    for (int i = 0; i < N_BARRILES; i++) begin
      cover_s[i] = (slot_st_r[i] != SL_IDLE) &&
                   ({1'b0, v_r[i]} < {1'b0, vcount}) && ({1'b0, vcount} < ({1'b0, v_r[i]} + 11'd16)) &&
                   ({1'b0, h_r[i]} < {1'b0, hcount}) && ({1'b0, hcount} < ({1'b0, h_r[i]} + 11'd16));
    end
  end

  // Priority select: lowest-index covering slot drives the sprite path
  always_comb begin
    sel_hit_s = 1'b0;
    sel_h_s   = 10'd0;
    sel_v_s   = 10'd0;
    for (int i = N_BARRILES - 1; i >= 0; i--) begin
      sel_hit_s = cover_s[i] | sel_hit_s;
      sel_h_s   = cover_s[i] ? h_r[i] : sel_h_s;
      sel_v_s   = cover_s[i] ? v_r[i] : sel_v_s;
    end
  end

  // Count of non-idle slots
  always_comb begin
    active_s = 4'd0;
    for (int i = 0; i < N_BARRILES; i++) begin
      active_s = active_s + {3'b000, (slot_st_r[i] != SL_IDLE)};
    end
  end

  // Controller FSM with slot storage, spawn counter and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_WAIT;
      idx_r       <= {IW{1'b0}};
      spawn_cnt_r <= {CW{1'b0}};
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      for (int i = 0; i < N_BARRILES; i++) begin
        slot_st_r[i] <= SL_IDLE;
        h_r[i]       <= 10'd0;
        v_r[i]       <= 10'd0;
        tgt_r[i]     <= 10'd0;
        dir_r[i]     <= DIR_R;
      end
`ifdef BARRIL_RANDOM_EN
      lfsr_r <= 8'h5A;
`endif
    end else if (clear) begin
      state_r     <= S_WAIT;
      idx_r       <= {IW{1'b0}};
      spawn_cnt_r <= {CW{1'b0}};
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      for (int i = 0; i < N_BARRILES; i++) begin
        slot_st_r[i] <= SL_IDLE;
        h_r[i]       <= 10'd0;
        v_r[i]       <= 10'd0;
        tgt_r[i]     <= 10'd0;
        dir_r[i]     <= DIR_R;
      end
    end else begin
      if (frame_tick && (state_r != S_WAIT)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        S_WAIT: begin
          if (frame_tick) begin
            state_r <= S_UPD;
            idx_r   <= {IW{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        S_UPD: begin
          slot_st_r[idx_r] <= nxt_st_s;
          h_r[idx_r]       <= nxt_h_s;
          v_r[idx_r]       <= nxt_v_s;
          tgt_r[idx_r]     <= nxt_tgt_s;
          dir_r[idx_r]     <= nxt_dir_s;
          if (idx_r == IW'(N_BARRILES - 1)) begin
            state_r <= S_SPAWN;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        S_SPAWN: begin
          state_r <= S_WAIT;
          idx_r   <= {IW{1'b0}};
          busy_r  <= 1'b0;
`ifdef BARRIL_RANDOM_EN
          lfsr_r  <= lfsr_next(lfsr_r);
`endif
          if (spawn_cnt_r == CW'(SPAWN_PERIOD - 1)) begin
            spawn_cnt_r <= {CW{1'b0}};
            if (spawn_en && spawn_hit_s) begin
              slot_st_r[spawn_idx_s] <= spawn_st_s;
              h_r[spawn_idx_s]       <= 10'(SPAWN_H);
              v_r[spawn_idx_s]       <= 10'(SPAWN_V);
              dir_r[spawn_idx_s]     <= DIR_R;
            end
          end else begin
            spawn_cnt_r <= spawn_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= S_WAIT;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Registered population count, one cycle behind slot state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 4'd0;
    end else begin
      active_r <= active_s;
    end
  end

  assign curr_h         = sel_h_s;
  assign curr_v         = sel_v_s;
  assign display_barril = sel_hit_s;
  assign busy           = busy_r;
  assign overrun        = overrun_r;
  assign active_count   = active_r;

endmodule

// File: tb/tb_barril_ctrl.sv
// Directed bench for barril_ctrl: spawn timing, roll/drop/despawn trajectory, pixel priority,
// full-slot spawn drop, overrun and clear. A second instance with SPAWN_PERIOD=1 exercises priority.
module tb_barril_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, spawn_en, clear;
  logic [9:0] hcount, vcount, curr_h, curr_v;
  logic       display_barril, busy, overrun;
  logic [3:0] active_count;

  logic       frame_tick_b, spawn_en_b, clear_b;
  logic [9:0] hcount_b, vcount_b, curr_h_b, curr_v_b;
  logic       display_barril_b, busy_b, overrun_b;
  logic [3:0] active_count_b;

  int n_vec = 0;
  int n_err = 0;
  int s_busy [10];
  int s_disp [10];
  int s_ch   [10];
  int s_cv   [10];
  int s_act  [10];
  int busy_cyc;

  always #5 clk = ~clk;

  barril_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .spawn_en(spawn_en), .clear(clear),
    .hcount(hcount), .vcount(vcount), .curr_h(curr_h), .curr_v(curr_v),
    .display_barril(display_barril), .busy(busy), .overrun(overrun), .active_count(active_count)
  );

  barril_ctrl #(.SPAWN_PERIOD(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick_b), .spawn_en(spawn_en_b), .clear(clear_b),
    .hcount(hcount_b), .vcount(vcount_b), .curr_h(curr_h_b), .curr_v(curr_v_b),
    .display_barril(display_barril_b), .busy(busy_b), .overrun(overrun_b), .active_count(active_count_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One frame on the main instance; records outputs for the 10 cycles after the tick is sampled
  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      s_busy[i] = int'(busy);
      s_disp[i] = int'(display_barril);
      s_ch[i]   = int'(curr_h);
      s_cv[i]   = int'(curr_v);
      s_act[i]  = int'(active_count);
      busy_cyc  = busy_cyc + int'(busy);
      @(negedge clk);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic probe(input string tag, input int hc, input int vc, input int ed, input int eh, input int ev);
    hcount = 10'(hc);
    vcount = 10'(vc);
    #1;
    chk({tag, "_disp"}, int'(display_barril), ed);
    chk({tag, "_h"}, int'(curr_h), eh);
    chk({tag, "_v"}, int'(curr_v), ev);
  endtask

  task automatic tick_b();
    frame_tick_b = 1'b1;
    @(negedge clk);
    frame_tick_b = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; spawn_en = 1'b0; clear = 1'b0; hcount = 10'd0; vcount = 10'd0;
    frame_tick_b = 1'b0; spawn_en_b = 1'b0; clear_b = 1'b0; hcount_b = 10'd0; vcount_b = 10'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_active", int'(active_count), 0);
    probe("rst_pix", 5, 5, 0, 0, 0);

    // Priority instance: spawns every frame, so two barrels overlap after the second tick
    spawn_en_b = 1'b1;
    tick_b();
    tick_b();
    chk("pri_active", int'(active_count_b), 2);
    hcount_b = 10'd50; vcount_b = 10'd85; #1;
    chk("pri_both_disp", int'(display_barril_b), 1);
    chk("pri_both_h", int'(curr_h_b), 42);
    chk("pri_both_v", int'(curr_v_b), 80);
    hcount_b = 10'd42; #1;
    chk("pri_fallthru_h", int'(curr_h_b), 40);
    spawn_en_b = 1'b0;

    // Spawn period: nothing for 119 frames, spawn on the 120th
    spawn_en = 1'b1;
    hcount = 10'd45; vcount = 10'd85;
    run_ticks(119);
    chk("act_119", int'(active_count), 0);
    do_tick();
    chk("spawn_busy_cyc", busy_cyc, 5);
    chk("spawn_busy_last", s_busy[4], 1);
    chk("spawn_busy_end", s_busy[5], 0);
    chk("spawn_not_yet", s_disp[4], 0);
    chk("spawn_vis", s_disp[5], 1);
    chk("spawn_h", s_ch[5], 40);
    chk("spawn_v", s_cv[5], 80);
    chk("spawn_act_lag", s_act[5], 0);
    chk("spawn_act", s_act[6], 1);
    spawn_en = 1'b0;

    // Single barrel trajectory, f counts frames since spawn
    do_tick();
    chk("upd0_old_h", s_ch[0], 40);
    chk("upd0_new_h", s_ch[1], 42);
    probe("f1", 45, 85, 1, 42, 80);
    probe("f1_strict", 42, 85, 0, 0, 0);
    run_ticks(282);
    probe("f283", 607, 85, 1, 606, 80);
    do_tick();
    probe("f284_edge", 610, 85, 1, 608, 80);
    do_tick();
    probe("f285_fall", 610, 90, 1, 608, 84);
    run_ticks(15);
    probe("f300_land", 610, 150, 1, 608, 144);
    do_tick();
    probe("f301_rolll", 607, 150, 1, 606, 144);
    run_ticks(311);
    probe("f612_left", 17, 210, 1, 16, 208);
    run_ticks(936);
    probe("f1548_bottom", 610, 405, 1, 608, 400);
    run_ticks(295);
    probe("f1843", 20, 405, 1, 18, 400);
    chk("f1843_act", int'(active_count), 1);
    do_tick();
    chk("despawn_before", s_disp[0], 1);
    chk("despawn_before_h", s_ch[0], 18);
    chk("despawn_gone", s_disp[1], 0);
    chk("despawn_act_lag", s_act[1], 1);
    chk("despawn_act", s_act[2], 0);

    // Fill all four slots, then a spawn attempt with no idle slot
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    spawn_en = 1'b1;
    hcount = 10'd45; vcount = 10'd85;
    run_ticks(480);
    chk("full_act", int'(active_count), 4);
    probe("full_slot3", 45, 85, 1, 40, 80);
    run_ticks(120);
    chk("drop_act", int'(active_count), 4);
    probe("drop_noload", 45, 85, 0, 0, 0);

    // Overrun: second tick lands while the sequence is running
    hcount = 10'd285; vcount = 10'd85;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    repeat (8) @(negedge clk);
    chk("overrun_idle", int'(busy), 0);
    chk("overrun_sticky", int'(overrun), 1);
    probe("overrun_ignored", 285, 85, 1, 282, 80);

    // Clear kills everything on the next edge
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_overrun", int'(overrun), 0);
    chk("clear_busy", int'(busy), 0);
    chk("clear_disp", int'(display_barril), 0);
    @(negedge clk);
    @(negedge clk);
    chk("clear_act", int'(active_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
